// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter and
// control-word decode with halt latch and synchronous clear.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] OPCODE,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_,
  output logic       Ce_,
  output logic       Li_,
  output logic       Ei_,
  output logic       La_,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_,
  output logic       Lo_,
  output logic       HLT
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  state_t state_q, state_d;
  logic   hlt_q, hlt_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  // Ring advances only while running; halt freezes it in T5.
  always_comb begin
    state_d = state_q;
    hlt_d   = hlt_q;
    if (!hlt_q) begin
      unique case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        default: state_d = T1;
      endcase
      if (state_q == T4 && OPCODE == OP_HLT)
        hlt_d = 1'b1;
    end
  end

  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    Lm_ = 1'b1;
    Ce_ = 1'b1;
    Li_ = 1'b1;
    Ei_ = 1'b1;
    La_ = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    Lb_ = 1'b1;
    Lo_ = 1'b1;
    if (!CLR && !hlt_q) begin
      unique case (state_q)
        T1: begin
          Ep  = 1'b1;
          Lm_ = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          Ce_ = 1'b0;
          Li_ = 1'b0;
        end
        T4: begin
          if (OPCODE == OP_LDA || OPCODE == OP_ADD ||
              OPCODE == OP_SUB) begin
            Ei_ = 1'b0;
            Lm_ = 1'b0;
          end else if (OPCODE == OP_OUT) begin
            Ea  = 1'b1;
            Lo_ = 1'b0;
          end
        end
        T5: begin
          if (OPCODE == OP_LDA) begin
            Ce_ = 1'b0;
            La_ = 1'b0;
          end else if (OPCODE == OP_ADD ||
                       OPCODE == OP_SUB) begin
            Ce_ = 1'b0;
            Lb_ = 1'b0;
            Su  = (OPCODE == OP_SUB);
          end
        end
        T6: begin
          if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
            Eu  = 1'b1;
            La_ = 1'b0;
            Su  = (OPCODE == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign T   = state_q;
  assign HLT = hlt_q;

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: a phase/halt model predicts
// every cycle's full output word plus one-hot and bus-driver checks.
module tb_sap_controller;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [3:0] OPCODE = 4'b0000;
  logic [5:0] T;
  logic Cp, Ep, Lm_, Ce_, Li_, Ei_, La_, Ea, Su, Eu, Lb_, Lo_, HLT;

  sap_controller dut (
    .CLK(CLK), .CLR(CLR), .OPCODE(OPCODE), .T(T),
    .Cp(Cp), .Ep(Ep), .Lm_(Lm_), .Ce_(Ce_), .Li_(Li_),
    .Ei_(Ei_), .La_(La_), .Ea(Ea), .Su(Su), .Eu(Eu),
    .Lb_(Lb_), .Lo_(Lo_), .HLT(HLT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ph = 0;
  bit halted = 1'b0;
  logic [18:0] sb[$];
  logic [18:0] obs, expw;

  // Word layout: T[5:0], Cp Ep Lm_ Ce_ Li_ Ei_ La_ Ea Su Eu Lb_ Lo_, HLT
  function automatic logic [18:0] model_word(
    input int p, input bit h, input logic c, input logic [3:0] op);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic [5:0] t;
    cp = 0; ep = 0; ea = 0; su = 0; eu = 0;
    lm = 1; ce = 1; li = 1; ei = 1; la = 1; lb = 1; lo = 1;
    t = 6'd1 << p;
    if (!c && !h) begin
      if (p == 0) begin ep = 1; lm = 0; end
      if (p == 1) cp = 1;
      if (p == 2) begin ce = 0; li = 0; end
      if (p == 3 && op inside {4'h0, 4'h1, 4'h2}) begin
        ei = 0; lm = 0;
      end
      if (p == 3 && op == 4'hE) begin ea = 1; lo = 0; end
      if (p == 4 && op == 4'h0) begin ce = 0; la = 0; end
      if (p == 4 && op inside {4'h1, 4'h2}) begin
        ce = 0; lb = 0; su = (op == 4'h2);
      end
      if (p == 5 && op inside {4'h1, 4'h2}) begin
        eu = 1; la = 0; su = (op == 4'h2);
      end
    end
    return {t, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, h};
  endfunction

  function automatic int drivers();
    return int'(Ep) + int'(!Ce_) + int'(!Ei_) + int'(Ea) + int'(Eu);
  endfunction

  task automatic drive(input logic c, input logic [3:0] op);
    CLR = c;
    OPCODE = op;
    sb.push_back(model_word(ph, halted, c, op));
    #1;
    obs = {T, Cp, Ep, Lm_, Ce_, Li_, Ei_, La_, Ea, Su, Eu,
           Lb_, Lo_, HLT};
    expw = sb.pop_front();
  endtask

  task automatic tick();
    @(posedge CLK);
    if (CLR) begin
      ph = 0;
      halted = 1'b0;
    end else if (!halted) begin
      if (ph == 3 && OPCODE == 4'hF) halted = 1'b1;
      ph = (ph + 1) % 6;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i < 2, 4'h5);
      checks++;
      if (obs !== expw) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, expw);
      end
      checks++;
      if (!$onehot(T) || drivers() > 1) begin
        failures++;
        $display("FAIL reset_bus cyc=%0d T=%b drv=%0d exp<=1", cyc, T,
                 drivers());
      end
      tick();
    end
  endtask

  task automatic test_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, op);
      checks++;
      if (obs !== expw) begin
        failures++;
        $display("FAIL instr_%h cyc=%0d got=%b exp=%b", op, cyc, obs,
                 expw);
      end
      checks++;
      if (!$onehot(T) || drivers() > 1) begin
        failures++;
        $display("FAIL instr_bus cyc=%0d T=%b drv=%0d exp<=1", cyc, T,
                 drivers());
      end
      tick();
    end
    checks++;
    if (T !== 6'b000001) begin
      failures++;
      $display("FAIL wrap_%h got=%b exp=000001", op, T);
    end
  endtask

  task automatic test_hlt();
    logic [3:0] op;
    for (int i = 0; i < 16; i++) begin
      op = (i < 4) ? 4'hF : 4'($urandom_range(0, 15));
      drive(i == 15, op);
      checks++;
      if (obs !== expw) begin
        failures++;
        $display("FAIL hlt cyc=%0d got=%b exp=%b", cyc, obs, expw);
      end
      checks++;
      if (!$onehot(T) || drivers() > 1) begin
        failures++;
        $display("FAIL hlt_bus cyc=%0d T=%b drv=%0d exp<=1", cyc, T,
                 drivers());
      end
      tick();
    end
    checks++;
    if ({T, HLT} !== 7'b0000010) begin
      failures++;
      $display("FAIL hlt_clear got=%b exp=0000010", {T, HLT});
    end
  endtask

  task automatic test_mid_clear();
    for (int i = 0; i < 7; i++) begin
      drive(i >= 4, 4'h1);
      checks++;
      if (obs !== expw) begin
        failures++;
        $display("FAIL mid_clear cyc=%0d got=%b exp=%b", cyc, obs, expw);
      end
      checks++;
      if (i >= 4 && La_ !== 1'b1) begin
        failures++;
        $display("FAIL mid_clear_la cyc=%0d got=%b exp=1", cyc, La_);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[5];
    ops = '{4'h2, 4'h0, 4'hE, 4'h1, 4'h7};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, ops[k]);
        checks++;
        if (obs !== expw) begin
          failures++;
          $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, expw);
        end
        checks++;
        if (!$onehot(T) || drivers() > 1) begin
          failures++;
          $display("FAIL b2b_bus cyc=%0d T=%b drv=%0d exp<=1", cyc, T,
                   drivers());
        end
        tick();
      end
    end
  endtask

  initial begin
    CLR = 1'b1;
    tick();
    test_reset();
    test_instr(4'h0);
    test_instr(4'h1);
    test_instr(4'h2);
    test_instr(4'hE);
    test_instr(4'h5);
    test_hlt();
    test_mid_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Controller-sequencer for the SAP-1 datapath. It is the stage directly upstream of the accumulator and generates its active-low load (La_) and its bus enable (Ea).
- A 6-state one-hot ring counter (T1..T6) steps through fetch and execute. Each state and opcode decode into the full control word that drives PC, MAR, RAM, IR, A, B, ALU and the output register.
- Adds halt detection and a synchronous clear.

Parameters:
- OP_LDA, 4'b0000, load-accumulator opcode
- OP_ADD, 4'b0001, add opcode
- OP_SUB, 4'b0010, subtract opcode
- OP_OUT, 4'b1110, output opcode
- OP_HLT, 4'b1111, halt opcode

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- CLR  in  1  reset, synchronous, active-high
- OPCODE  in  4  IR upper nibble; valid from T4 onward
- T  out  6  one-hot ring state; bit0=T1 .. bit5=T6
- Cp  out  1  PC increment (active-high)
- Ep  out  1  PC to bus (active-high)
- Lm_  out  1  MAR load (active-low)
- Ce_  out  1  RAM to bus (active-low)
- Li_  out  1  IR load (active-low)
- Ei_  out  1  IR operand to bus (active-low)
- La_  out  1  A load (active-low)
- Ea  out  1  A to bus (active-high)
- Su  out  1  ALU subtract select (active-high)
- Eu  out  1  ALU to bus (active-high)
- Lb_  out  1  B load (active-low)
- Lo_  out  1  output register load (active-low)
- HLT  out  1  halted flag (active-high)

Behaviour:
- Clock and reset: one clock (CLK). Reset CLR is synchronous and active-high.
- Idle word: Cp=Ep=Ea=Su=Eu=0 and Lm_=Ce_=Li_=Ei_=La_=Lb_=Lo_=1.
- Reset: CLR sampled high at a rising edge gives T=6'b000001 and HLT=0.
  - While CLR is high, the outputs are forced to the idle word regardless of state.
  - CLR overrides everything, including a halt and a mid-instruction state.
- Ring counter: on each rising edge with CLR=0 and HLT=0, T rotates left: T1→T2→…→T6→T1. T is always exactly one-hot.
- Control word: combinational decode of registered T and OPCODE. It is stable for the whole cycle and sampled by downstream registers on the next rising edge. Signals not listed for a state are idle.
  - T1: Ep=1, Lm_=0 (address state).
  - T2: Cp=1 (increment state).
  - T3: Ce_=0, Li_=0 (memory state; IR loads at the end of T3).
  - LDA: T4 Ei_=0, Lm_=0; T5 Ce_=0, La_=0; T6 idle.
  - ADD: T4 Ei_=0, Lm_=0; T5 Ce_=0, Lb_=0; T6 Eu=1, La_=0, Su=0.
  - SUB: as ADD, but Su=1 during both T5 and T6.
  - OUT: T4 Ea=1, Lo_=0; T5 and T6 idle.
  - HLT: in T4, HLT is set at the next rising edge and the outputs are idle.
  - Any other opcode: T4–T6 idle (NOP); the counter continues.
- Halt:
  - Once HLT=1, T freezes at T5 (the state reached on the edge that set HLT) and the outputs stay idle.
  - Only CLR clears HLT.
  - OPCODE changes while halted have no effect.
- Bus-contention guard: at most one of Ep, Ce_(low), Ei_(low), Ea, Eu drives the bus in any state. The verification bench asserts this every cycle.
- Instruction length: every instruction takes exactly 6 cycles, T1 to the next T1.
- OPCODE is ignored in T1–T3.

Test Plan:
- Reset: CLR=1 for 2 cycles, then 0 → T=000001 with the idle word during CLR. In the first cycle after release, Ep=1 and Lm_=0. HLT=0.
- LDA: OPCODE=0000, run 6 cycles from T1 → T4 gives Ei_=0, Lm_=0; T5 gives Ce_=0, La_=0; T6 idle; the next cycle is T=000001.
- SUB: OPCODE=0010 → T5 gives Ce_=0, Lb_=0, Su=1; T6 gives Eu=1, La_=0, Su=1. ADD (0001) gives the same with Su=0 throughout.
- OUT then NOP: OPCODE=1110 → T4 gives Ea=1, Lo_=0. Then OPCODE=0101 → T4–T6 fully idle and the ring still wraps.
- HLT: OPCODE=1111 at T4 → the next edge gives HLT=1 and T=010000. T stays frozen and the outputs stay idle for 10 further cycles. Assert CLR → T=000001, HLT=0.
- Mid-instruction clear: CLR=1 in T5 of an ADD → T=000001 at that edge, La_ is never asserted, and the idle word holds while CLR is high.
- All scenarios: the one-hot and single-bus-driver assertions are checked every cycle.
